// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin merge of ALU and load writebacks onto one register-file write port
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        rf_write,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_reg_write,
    output logic        alu_pending,
    output logic        mem_pending,
    output logic [15:0] conflict_cnt
);
    typedef enum logic {ALU = 1'b0, MEM = 1'b1} src_t;
    logic        alu_v, mem_v;
    logic [4:0]  alu_r, mem_r;
    logic [31:0] alu_d, mem_d;
    logic        alu_grant, mem_grant;
    src_t        last_grant;
    // Grant depends only on buffer state; on contention the requester not served last wins
    always_comb begin
        alu_grant = alu_v && (!mem_v || last_grant == MEM);
        mem_grant = mem_v && (!alu_v || last_grant == ALU);
    end
    assign alu_ready    = !alu_v || alu_grant;
    assign mem_ready    = !mem_v || mem_grant;
    assign alu_pending  = alu_v;
    assign mem_pending  = mem_v;
    assign rf_write     = (alu_grant && alu_r != 5'd0) || (mem_grant && mem_r != 5'd0);
    assign rf_rd        = !rf_write ? 5'd0 : alu_grant ? alu_r : mem_r;
    assign rf_reg_write = !rf_write ? 32'd0 : alu_grant ? alu_d : mem_d;
    // ALU holding buffer: a refill in the same cycle as its drain keeps it valid
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            alu_v <= 1'b0;
            alu_r <= 5'd0;
            alu_d <= 32'd0;
        end else if (alu_valid && alu_ready) begin
            alu_v <= 1'b1;
            alu_r <= alu_rd;
            alu_d <= alu_data;
        end else if (alu_grant) alu_v <= 1'b0;
    // Load holding buffer, same drain/refill behaviour as the ALU side
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            mem_v <= 1'b0;
            mem_r <= 5'd0;
            mem_d <= 32'd0;
        end else if (mem_valid && mem_ready) begin
            mem_v <= 1'b1;
            mem_r <= mem_rd;
            mem_d <= mem_data;
        end else if (mem_grant) mem_v <= 1'b0;
    // Round-robin pointer and saturating contention counter
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            last_grant   <= MEM;
            conflict_cnt <= 16'd0;
        end else begin
            last_grant <= alu_grant ? ALU : mem_grant ? MEM : last_grant;
            if (alu_v && mem_v && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
        end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scoreboard bench for the writeback arbiter
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, rf_write, alu_pending, mem_pending;
    logic [4:0]  rf_rd;
    logic [31:0] rf_reg_write;
    logic [15:0] conflict_cnt;

    typedef struct packed {logic [4:0] rd; logic [31:0] data;} ent_t;
    ent_t alu_q[$];
    ent_t mem_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   alu_acc, mem_acc, alt_on, prev_wr, prev_src, alu_lo, mem_lo;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_write(rf_write), .rf_rd(rf_rd), .rf_reg_write(rf_reg_write),
        .alu_pending(alu_pending), .mem_pending(mem_pending), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Per-cycle scoreboard: match writes against accepted requests, then record new acceptances
    task automatic mon();
        ent_t e;
        bit   hit, src;
        hit = 1'b0;
        src = 1'b0;
        if (rf_write) begin
            if (alu_q.size() > 0 && alu_q[0].rd == rf_rd) begin hit = 1'b1; src = 1'b0; end
            else if (mem_q.size() > 0 && mem_q[0].rd == rf_rd) begin hit = 1'b1; src = 1'b1; end
            if (!hit) begin
                if (alu_q.size() > 0) chk("write_rd", 32'(rf_rd), 32'(alu_q[0].rd));
                else if (mem_q.size() > 0) chk("write_rd", 32'(rf_rd), 32'(mem_q[0].rd));
                else chk("spurious_write", 32'(rf_write), 32'd0);
            end else begin
                if (alt_on && prev_wr && alu_q.size() > 0 && mem_q.size() > 0)
                    chk("alternate", 32'(src), 32'(!prev_src));
                e = src ? mem_q.pop_front() : alu_q.pop_front();
                chk("write_data", rf_reg_write, e.data);
                prev_src = src;
            end
        end else begin
            chk("idle_rd", 32'(rf_rd), 32'd0);
            chk("idle_data", rf_reg_write, 32'd0);
        end
        prev_wr = rf_write;
        if (alt_on) begin
            chk("alu_ready_gap", 32'(alu_lo && !alu_ready), 32'd0);
            chk("mem_ready_gap", 32'(mem_lo && !mem_ready), 32'd0);
        end
        alu_lo  = !alu_ready;
        mem_lo  = !mem_ready;
        alu_acc = alu_valid && alu_ready && rst;
        mem_acc = mem_valid && mem_ready && rst;
        if (alu_acc && alu_rd != 5'd0) alu_q.push_back('{alu_rd, alu_data});
        if (mem_acc && mem_rd != 5'd0) mem_q.push_back('{mem_rd, mem_data});
    endtask

    task automatic cycle();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && (alu_q.size() > 0 || mem_q.size() > 0); i++) cycle();
        chk("drain_alu", 32'(alu_q.size()), 32'd0);
        chk("drain_mem", 32'(mem_q.size()), 32'd0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_rf_write"}, 32'(rf_write), 32'd0);
        chk({tag, "_rf_rd"}, 32'(rf_rd), 32'd0);
        chk({tag, "_rf_data"}, rf_reg_write, 32'd0);
        chk({tag, "_alu_pending"}, 32'(alu_pending), 32'd0);
        chk({tag, "_mem_pending"}, 32'(mem_pending), 32'd0);
        chk({tag, "_alu_ready"}, 32'(alu_ready), 32'd1);
        chk({tag, "_mem_ready"}, 32'(mem_ready), 32'd1);
        chk({tag, "_conflict"}, 32'(conflict_cnt), 32'd0);
    endtask

    initial begin
        int an, mn, wr;
        rst = 1'b0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
        alt_on = 1'b0; prev_wr = 1'b0; prev_src = 1'b0; alu_lo = 1'b0; mem_lo = 1'b0;
        #1;
        reset_checks("reset");
        cycle();
        cycle();
        rst = 1'b1;

        // single uncontended ALU write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        cycle();
        alu_valid = 1'b0;
        chk("single_wr", 32'(rf_write), 32'd1);
        chk("single_rd", 32'(rf_rd), 32'd5);
        chk("single_data", rf_reg_write, 32'hDEADBEEF);
        cycle();
        chk("single_done", 32'(rf_write), 32'd0);

        // contention straight after reset: ALU first, then MEM
        rst = 1'b0;
        #1;
        reset_checks("reset2");
        cycle();
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'd1;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'd2;
        cycle();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("cont_first_rd", 32'(rf_rd), 32'd1);
        chk("cont_first_wr", 32'(rf_write), 32'd1);
        cycle();
        chk("cont_second_rd", 32'(rf_rd), 32'd2);
        chk("cont_second_data", rf_reg_write, 32'd2);
        chk("cont_conflict", 32'(conflict_cnt), 32'd1);
        cycle();
        chk("cont_done", 32'(rf_write), 32'd0);

        // back-to-back streams, 8 requests each
        alt_on = 1'b1;
        an = 0; mn = 0;
        for (int i = 0; i < 40 && (an < 8 || mn < 8); i++) begin
            alu_valid = an < 8; alu_rd = 5'(an + 1);  alu_data = 32'hA000_0000 + 32'(an);
            mem_valid = mn < 8; mem_rd = 5'(mn + 16); mem_data = 32'hB000_0000 + 32'(mn);
            cycle();
            if (alu_acc) an++;
            if (mem_acc) mn++;
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("stream_accepted", 32'(an + mn), 32'd16);
        drain();
        alt_on = 1'b0;

        // x0 destination is drained silently and takes the round-robin turn
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        cycle();
        alu_valid = 1'b0;
        chk("x0_pending", 32'(alu_pending), 32'd1);
        chk("x0_no_write", 32'(rf_write), 32'd0);
        cycle();
        chk("x0_cleared", 32'(alu_pending), 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd3;  alu_data = 32'h33;
        mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'h44;
        cycle();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("x0_mem_first", 32'(rf_rd), 32'd20);
        cycle();
        chk("x0_alu_second", 32'(rf_rd), 32'd3);
        drain();

        // reset while both buffers hold requests
        alu_valid = 1'b1; alu_rd = 5'd4;  alu_data = 32'h4444;
        mem_valid = 1'b1; mem_rd = 5'd21; mem_data = 32'h2121;
        cycle();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("mid_both_full", 32'({alu_pending, mem_pending}), 32'd3);
        rst = 1'b0;
        #1;
        reset_checks("mid_reset");
        alu_q.delete();
        mem_q.delete();
        cycle();
        rst = 1'b1;
        wr = 0;
        for (int i = 0; i < 4; i++) begin
            wr += int'(rf_write);
            cycle();
        end
        chk("mid_no_write", 32'(wr), 32'd0);
        chk("mid_conflict", 32'(conflict_cnt), 32'd0);

        // counter saturation under permanent contention
        alu_valid = 1'b1; alu_rd = 5'd7;  alu_data = 32'h7777;
        mem_valid = 1'b1; mem_rd = 5'd22; mem_data = 32'h2222;
        for (int i = 0; i < 65540; i++) cycle();
        chk("sat_conflict", 32'(conflict_cnt), 32'h0000FFFF);
        cycle();
        chk("sat_hold", 32'(conflict_cnt), 32'h0000FFFF);
        alu_valid = 1'b0; mem_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port alu_valid  input  1  ALU writeback request present.
REQ-004 SHALL have port alu_rd  input  5  ALU destination register index.
REQ-005 SHALL have port alu_data  input  32  ALU result.
REQ-006 SHALL have port alu_ready  output  1  ALU request accepted this cycle when high with alu_valid.
REQ-007 SHALL have port mem_valid  input  1  load writeback request present.
REQ-008 SHALL have port mem_rd  input  5  load destination register index.
REQ-009 SHALL have port mem_data  input  32  load data.
REQ-010 SHALL have port mem_ready  output  1  load request accepted this cycle when high with mem_valid.
REQ-011 SHALL have port rf_write  output  1  write enable to register file.
REQ-012 SHALL have port rf_rd  output  5  register file write index.
REQ-013 SHALL have port rf_reg_write  output  32  register file write data.
REQ-014 SHALL have port alu_pending  output  1  ALU holding buffer occupied.
REQ-015 SHALL have port mem_pending  output  1  load holding buffer occupied.
REQ-016 SHALL have port conflict_cnt  output  16  saturating count of contended cycles.

Function
REQ-017 SHALL hold one holding buffer per requester (valid bit, 5-bit rd, 32-bit data).
REQ-018 SHALL capture a request into its buffer on a clock edge where valid && ready.
REQ-019 SHALL drive alu_ready = !alu_buf_v || alu_grant; mem_ready likewise; combinational, no dependence on alu_valid/mem_valid.
REQ-020 SHALL compute grant combinationally from buffer state only: one buffer full -> grant it; both full -> grant requester not named by last_grant; none -> no grant.
REQ-021 SHALL clear the granted buffer at the next edge unless a new request is captured into it in the same cycle (simultaneous drain and refill keeps buffer valid with new contents).
REQ-022 SHALL update last_grant to the granted requester on every grant; hold otherwise.
REQ-023 SHALL drive rf_write = 1, rf_rd = buffer rd, rf_reg_write = buffer data while a buffer with rd != 0 is granted.
REQ-024 SHALL, for a granted buffer with rd == 0, drain it normally (counts as grant, updates last_grant) with rf_write = 0.
REQ-025 SHALL drive rf_rd = 0 and rf_reg_write = 0 whenever rf_write = 0.
REQ-026 SHALL have latency of exactly one cycle from acceptance to rf_write when uncontended; max wait under contention two cycles (round-robin bound).
REQ-027 SHALL sustain one write per cycle with both requesters continuously valid (alternating grants).
REQ-028 SHALL increment conflict_cnt in every cycle both buffers are valid, saturating at 16'hFFFF.
REQ-029 SHALL drive alu_pending/mem_pending directly from buffer valid bits.
REQ-030 SHALL never assert rf_write for more than one buffer per cycle and never drop or duplicate an accepted request.

Reset
REQ-031 SHALL, while rst = 0, asynchronously clear both buffers (valid, rd, data), set last_grant = MEM, clear conflict_cnt.
REQ-032 SHALL, during reset, output rf_write = 0, rf_rd = 0, rf_reg_write = 0, alu_pending = 0, mem_pending = 0, alu_ready = 1, mem_ready = 1.
REQ-033 SHALL discard any buffered request when reset asserts mid-operation; no write issued for it after release.

Verification
REQ-034 SHALL cover single ALU write: alu_valid=1, rd=5, data=32'hDEADBEEF at cycle 0 -> cycle 1 rf_write=1, rf_rd=5, rf_reg_write=32'hDEADBEEF; cycle 2 rf_write=0.
REQ-035 SHALL cover contention after reset: both valid same cycle (ALU rd=1 data=1, MEM rd=2 data=2) -> cycle 1 writes rd=1, cycle 2 writes rd=2, conflict_cnt=1.
REQ-036 SHALL cover back-to-back streams: both valid 8 cycles with distinct rd -> 8+ writes alternating ALU/MEM, none lost, ready never low two consecutive cycles for either port.
REQ-037 SHALL cover x0 drop: alu_valid rd=0 data=32'h1234 -> no rf_write, alu_pending clears after one cycle, last_grant = ALU.
REQ-038 SHALL cover reset mid-operation: both buffers full, rst pulses low -> pending=0, ready=1 immediately, no rf_write after release, conflict_cnt=0.
REQ-039 SHALL cover counter saturation: forced contention 65540 cycles -> conflict_cnt holds 16'hFFFF.
